regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
Shares the register file's two read ports (readRegister1/2 -> readData1/2, combinational 32x64 read mux) among NUM_REQ requesters.
- Each requester asks for two source registers; one requester wins per cycle, round-robin.
- Read data is captured into a one-entry response register with valid/ready back-pressure.
- Sits between decode/issue units and the register file read mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, register width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_ra1  in  NUM_REQ x ADDR_W  source register 1 address per requester
req_ra2  in  NUM_REQ x ADDR_W  source register 2 address per requester
rf_readRegister1  out  ADDR_W  to register file read port 1
rf_readRegister2  out  ADDR_W  to register file read port 2
rf_readData1  in  DATA_W  from register file port 1, same cycle
rf_readData2  in  DATA_W  from register file port 2, same cycle
rsp_valid  out  1  response holds valid data
rsp_ready  in  1  consumer accepts response
rsp_id  out  $clog2(NUM_REQ)  index of the requester the response belongs to
rsp_data1  out  DATA_W  value of ra1
rsp_data2  out  DATA_W  value of ra2

Behaviour:
- Reset (reset_n low, async): rsp_valid=0, rsp_id=0, rsp_data1/2=0, rr_ptr=0. Any held response is dropped; pending requests are not remembered.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Arbitration (combinational): if can_accept, winner = first i with req_valid[i], scanning from rr_ptr upward with wrap at NUM_REQ. req_ready[winner]=1; all other bits 0. If !can_accept, req_ready = 0.
- rf_readRegister1/2 = winner's ra1/ra2. With no winner, both drive 0.
- Accept edge (req_valid & req_ready):
  - rsp_valid<=1, rsp_id<=winner.
  - rsp_data1 <= (ra1==31) ? 0 : rf_readData1. Same rule for rsp_data2. Register 31 is XZR.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- Latency: one cycle from accept to rsp_valid. Throughput: one request per cycle while rsp_ready stays high.
- rsp_ready high with no new accept: rsp_valid<=0 and data held.
- Simultaneous rsp_ready and new accept: the new response replaces the old one with no bubble.
- rsp_valid high and rsp_ready low: response outputs stay stable and req_ready=0.
- No accept: rr_ptr is unchanged.
- A requester must hold valid and addresses until it is accepted. The arbiter does not check this.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

Optional Feature:
REGFILE_ARB_BYPASS_EN
- Defined: adds input ports wr_en (1), wr_addr (ADDR_W) and wr_data (DATA_W), taken from the register file write port.
  - On an accept, a source address equal to wr_addr with wr_en=1 and addr!=31 captures wr_data instead of rf_readData. This is write-to-read forwarding.
  - ra1 and ra2 are compared independently.
- Not defined: these ports do not exist and data comes only from the register file. Register 31 still reads as zero.

Decomposition:
- Package regfile_pkg: REG_COUNT=32, ADDR_W=5, DATA_W=64, XZR_ADDR=5'd31, and a packed response struct {id, data1, data2}.
- Sub-module rr_arbiter (parameter N; inputs req, ptr, enable; outputs grant one-hot and grant_idx). It holds the rotating priority scan.

Test Plan:
- After reset, req_valid=4'b0001, ra1=3, ra2=31, rf_readData1=0xAA -> rf_readRegister1=3 and req_ready=0001 the same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_data1=0xAA, rsp_data2=0.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, with rsp_id following one cycle later.
- rsp_ready=0 while rsp_valid=1 for 3 cycles -> req_ready=0 and the response is held stable. Raising rsp_ready -> a new accept happens in the same cycle with no bubble.
- Reset asserted mid-stream with rsp_valid=1 -> rsp_valid=0 immediately (asynchronous), rr_ptr=0, and requester 0 wins first after release.
- Bypass build: wr_en=1, wr_addr=7, wr_data=0x55, accepted ra1=7 -> rsp_data1=0x55. With wr_addr=31 -> rsp_data1=0.
- Requester 2 alone valid while rr_ptr=3 -> wrap-around grants 2. rr_ptr becomes 3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and response record for the register-file read arbiter.
package regfile_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ID_W      = 3;
  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

  // The id field is sized for the largest supported requester count (8)
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } rsp_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between requesters, their consumer and the read arbiter.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_ra1;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_ra2;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [IDW-1:0]                 rsp_id;
  logic [DATA_W-1:0]              rsp_data1;
  logic [DATA_W-1:0]              rsp_data2;

  modport master (
    output req_valid, req_ra1, req_ra2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_ra1, req_ra2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_read_arbiter_rr.sv
// Rotating-priority scan: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the register file read ports with a one-entry response register.
// Optional write-to-read forwarding is enabled by defining REGFILE_ARB_BYPASS_EN.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_read_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]    rf_readRegister1,
  output logic [ADDR_W-1:0]    rf_readRegister2,
`ifdef REGFILE_ARB_BYPASS_EN
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
`endif
  input  logic [DATA_W-1:0]    rf_readData1,
  input  logic [DATA_W-1:0]    rf_readData2
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     rr_ptr;
  logic               rsp_valid_q;
  rsp_t               rsp_q;
  logic               can_accept;
  logic               accept;
  logic [ADDR_W-1:0]  ra1, ra2;
  logic [DATA_W-1:0]  d1, d2;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .enable    (can_accept),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  // grant is only ever set on a valid requester, so any grant bit is an accept
  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    ra1 = '0;
    ra2 = '0;
    if (accept) begin
      ra1 = bus.req_ra1[win_idx];
      ra2 = bus.req_ra2[win_idx];
    end
  end

  assign rf_readRegister1 = ra1;
  assign rf_readRegister2 = ra2;

  always_comb begin
    d1 = rf_readData1;
    d2 = rf_readData2;
`ifdef REGFILE_ARB_BYPASS_EN
    if (wr_en && wr_addr == ra1) d1 = wr_data;
    if (wr_en && wr_addr == ra2) d2 = wr_data;
`endif
    if (ra1 == XZR_ADDR) d1 = '0;
    if (ra2 == XZR_ADDR) d2 = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q.id    <= ID_W'(win_idx);
      rsp_q.data1 <= d1;
      rsp_q.data2 <= d2;
      rr_ptr      <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = IDW'(rsp_q.id);
  assign bus.rsp_data1 = rsp_q.data1;
  assign bus.rsp_data2 = rsp_q.data2;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed plus randomized checks of regfile_read_arbiter against a queue-free behavioural model.
module tb_regfile_read_arbiter;
  import regfile_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NUM_REQ(N), .DATA_W(64), .ADDR_W(5)) bus ();

  logic [4:0]  rf_ra1, rf_ra2;
  logic [63:0] rf_rd1, rf_rd2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] regs [32];

  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  regfile_read_arbiter #(.NUM_REQ(N), .DATA_W(64), .ADDR_W(5)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .rf_readRegister1 (rf_ra1),
    .rf_readRegister2 (rf_ra2),
`ifdef REGFILE_ARB_BYPASS_EN
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
`endif
    .rf_readData1     (rf_rd1),
    .rf_readData2     (rf_rd2)
  );

  int nvec = 0;
  int nerr = 0;

  bit          m_valid;
  int          m_id, m_ptr;
  logic [63:0] m_d1, m_d2;
  int          last_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value a source register should read as at the accept edge
  function automatic logic [63:0] src_val(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
`ifdef REGFILE_ARB_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return regs[a];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_ptr = 0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic cycle();
    bit can;
    int win;
    logic [N-1:0] er;
    logic [63:0] n1, n2;
    #1;
    can = !m_valid || bus.rsp_ready;
    win = -1;
    if (can)
      for (int k = 0; k < N; k++)
        if (win < 0 && bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    er = '0;
    n1 = '0; n2 = '0;
    if (win >= 0) begin
      er[win] = 1'b1;
      n1 = src_val(bus.req_ra1[win]);
      n2 = src_val(bus.req_ra2[win]);
    end
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("rf_ra1", 64'(rf_ra1), (win >= 0) ? 64'(bus.req_ra1[win]) : 64'd0);
    chk("rf_ra2", 64'(rf_ra2), (win >= 0) ? 64'(bus.req_ra2[win]) : 64'd0);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
    chk("rsp_data1", bus.rsp_data1, m_d1);
    chk("rsp_data2", bus.rsp_data2, m_d2);
    last_win = win;
    @(posedge clk);
    if (win >= 0) begin
      m_valid = 1; m_id = win; m_d1 = n1; m_d2 = n2; m_ptr = (win + 1) % N;
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [4:0] a1, input logic [4:0] a2);
    bus.req_valid[i] = 1'b1;
    bus.req_ra1[i]   = a1;
    bus.req_ra2[i]   = a2;
  endtask

  function automatic logic [4:0] pick_addr();
    int r = $urandom % 8;
    if (r == 0) return 5'd31;
    if (r == 1) return wr_addr;
    return 5'($urandom);
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.req_valid = '0; bus.req_ra1 = '0; bus.req_ra2 = '0; bus.rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[31] = 64'hDEAD_BEEF_0BAD_F00D;
    regs[3]  = 64'hAA;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cycle();                                      // idle state after reset

    // first request: ra1=3, ra2=XZR
    bus.rsp_ready = 1'b1;
    set_req(0, 5'd3, 5'd31);
    cycle();
    bus.req_valid = '0;
    #1;
    chk("tp1_data1", bus.rsp_data1, 64'hAA);
    chk("tp1_data2", bus.rsp_data2, 64'd0);
    cycle();

    // back-pressure: response held, no accepts, then no-bubble replacement
    bus.rsp_ready = 1'b0;
    set_req(1, 5'd5, 5'd6);
    cycle();
    bus.req_valid[1] = 1'b0;
    set_req(2, 5'd8, 5'd9);
    for (int c = 0; c < 3; c++) cycle();
    bus.rsp_ready = 1'b1;
    #1;
    chk("nobubble_ready", 64'(bus.req_ready), 64'h4);
    cycle();
    bus.req_valid = '0;
    cycle();

    // all requesters continuously valid
    for (int i = 0; i < N; i++) set_req(i, 5'($urandom), 5'($urandom));
    for (int c = 0; c < 3; c++) cycle();

    // asynchronous reset while a response is held
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_id", 64'(bus.rsp_id), 64'd0);
    chk("arst_data1", bus.rsp_data1, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rr_order", 64'(last_win), 64'(c % N));
    end

    // wrap-around: requester 2 alone while the pointer sits at 3
    bus.req_valid = '0;
    set_req(2, 5'd1, 5'd2);
    cycle();
    set_req(2, 5'd10, 5'd11);
    #1;
    chk("wrap_grant", 64'(bus.req_ready), 64'h4);
    cycle();
    for (int i = 0; i < N; i++) set_req(i, 5'($urandom), 5'($urandom));
    #1;
    chk("ptr_after_wrap", 64'(bus.req_ready), 64'h8);
    cycle();
    bus.req_valid = '0;
    cycle();

`ifdef REGFILE_ARB_BYPASS_EN
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
    set_req(0, 5'd7, 5'd4);
    cycle();
    bus.req_valid = '0;
    #1;
    chk("bypass_data1", bus.rsp_data1, 64'h55);
    wr_addr = 5'd31;
    set_req(1, 5'd31, 5'd4);
    cycle();
    bus.req_valid = '0;
    #1;
    chk("bypass_xzr", bus.rsp_data1, 64'd0);
    wr_en = 1'b0;
    cycle();
`endif

    // randomized traffic; requesters hold until accepted
    for (int c = 0; c < 400; c++) begin
      if (last_win >= 0) bus.req_valid[last_win] = 1'b0;
      wr_en   = $urandom % 2 == 0;
      wr_addr = 5'($urandom);
      wr_data = {$urandom, $urandom};
      regs[$urandom % 31] = {$urandom, $urandom};
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && ($urandom % 2 == 0)) set_req(i, pick_addr(), pick_addr());
      bus.rsp_ready = ($urandom % 4) != 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
